// File: rtl/rf_seq_pkg.sv
// Shared definitions for the register-file op sequencer: bus widths,
// opcode encodings and the sequencing FSM states.
package rf_seq_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned ADDR_W_DEF = 3;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_ADDI = 3'b101,
    OP_LI   = 3'b110,
    OP_NOP  = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_EXEC  = 2'd2,
    S_WRITE = 2'd3
  } state_e;

endpackage

// File: rtl/rf_seq_alu.sv
// Combinational ALU for the op sequencer; all arithmetic wraps mod 2^DATA_W
// and a NOP yields zero so the retired result reads 0.
module rf_seq_alu
  import rf_seq_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  op_e               op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [DATA_W-1:0] imm_i,
  output logic [DATA_W-1:0] res_o
);

  always_comb begin
    res_o = '0;
    case (op_i)
      OP_ADD:  res_o = a_i + b_i;
      OP_SUB:  res_o = a_i - b_i;
      OP_AND:  res_o = a_i & b_i;
      OP_OR:   res_o = a_i | b_i;
      OP_XOR:  res_o = a_i ^ b_i;
      OP_ADDI: res_o = a_i + imm_i;
      OP_LI:   res_o = imm_i;
      OP_NOP:  res_o = '0;
      default: res_o = '0;
    endcase
  end

endmodule

// File: rtl/rf_op_sequencer.sv
// Initiator for the 8x8 register-file port: accepts one command per handshake,
// reads operands, computes the ALU result and writes it back in four cycles.
module rf_op_sequencer
  import rf_seq_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic [ADDR_W-1:0] in_rs,
  input  logic [ADDR_W-1:0] in_rt,
  input  logic [DATA_W-1:0] in_imm,
  output logic              out_done,
  output logic [DATA_W-1:0] out_result,
  output logic              WEN,
  output logic [ADDR_W-1:0] RW,
  output logic [DATA_W-1:0] busW,
  output logic [ADDR_W-1:0] RX,
  output logic [ADDR_W-1:0] RY,
  input  logic [DATA_W-1:0] busX,
  input  logic [DATA_W-1:0] busY
);

  state_e              state_q, state_d;
  op_e                 op_q, op_d;
  logic [ADDR_W-1:0]   rd_q, rd_d;
  logic [DATA_W-1:0]   imm_q, imm_d;
  logic [ADDR_W-1:0]   rx_q, rx_d;
  logic [ADDR_W-1:0]   ry_q, ry_d;
  logic [DATA_W-1:0]   opa_q, opa_d;
  logic [DATA_W-1:0]   opb_q, opb_d;
  logic [DATA_W-1:0]   res_q, res_d;
  logic                wen_q, wen_d;
  logic [ADDR_W-1:0]   rw_q, rw_d;
  logic [DATA_W-1:0]   busw_q, busw_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic [DATA_W-1:0]   alu_res;

  rf_seq_alu #(.DATA_W(DATA_W)) u_alu (
    .op_i  (op_q),
    .a_i   (opa_q),
    .b_i   (opb_q),
    .imm_i (imm_q),
    .res_o (alu_res)
  );

  assign in_ready = (state_q == S_IDLE);

  // RX/RY are loaded at the accept edge so the register file is already
  // presenting the source operands throughout READ.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rd_d     = rd_q;
    imm_d    = imm_q;
    rx_d     = rx_q;
    ry_d     = ry_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    res_d    = res_q;
    wen_d    = 1'b0;
    rw_d     = rw_q;
    busw_d   = busw_q;
    done_d   = 1'b0;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_READ;
          op_d    = op_e'(in_op);
          rd_d    = in_rd;
          imm_d   = in_imm;
          rx_d    = in_rs;
          ry_d    = in_rt;
        end
      end
      S_READ: begin
        opa_d   = busX;
        opb_d   = busY;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        res_d   = alu_res;
        wen_d   = (op_q != OP_NOP) && (rd_q != '0);
        rw_d    = rd_q;
        busw_d  = alu_res;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        done_d   = 1'b1;
        result_d = res_q;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= OP_ADD;
      rd_q     <= '0;
      imm_q    <= '0;
      rx_q     <= '0;
      ry_q     <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      res_q    <= '0;
      wen_q    <= 1'b0;
      rw_q     <= '0;
      busw_q   <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      imm_q    <= imm_d;
      rx_q     <= rx_d;
      ry_q     <= ry_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      res_q    <= res_d;
      wen_q    <= wen_d;
      rw_q     <= rw_d;
      busw_q   <= busw_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign WEN        = wen_q;
  assign RW         = rw_q;
  assign busW       = busw_q;
  assign RX         = rx_q;
  assign RY         = ry_q;
  assign out_done   = done_q;
  assign out_result = result_q;

endmodule
